// File: rtl/cavlc_mb_sequencer_if.sv
// Handshake and neighbour-data bundle between the macroblock sequencer and its
// surroundings (slice control, CAVLC core, neighbour TotalCoeff store).
interface cavlc_mb_sequencer_if #(
    parameter int unsigned LEVEL_W = 13,
    parameter int unsigned TC_W    = 5
);
    logic                 mb_start_i;
    logic                 mb_abort_i;
    logic                 left_avail_i;
    logic                 top_avail_i;
    logic [4*TC_W-1:0]    left_tc_i;
    logic [4*TC_W-1:0]    top_tc_i;
    logic                 blk_start_o;
    logic [3:0]           blk_idx_o;
    logic [TC_W-1:0]      blk_nc_o;
    logic [LEVEL_W-1:0]   level_i;
    logic                 wr_req_i;
    logic                 block_done_i;
    logic                 busy_o;
    logic                 mb_done_o;
    logic [4*TC_W-1:0]    bot_tc_o;
    logic [4*TC_W-1:0]    right_tc_o;

    modport slave (
        input  mb_start_i, mb_abort_i, left_avail_i, top_avail_i,
        input  left_tc_i, top_tc_i, level_i, wr_req_i, block_done_i,
        output blk_start_o, blk_idx_o, blk_nc_o, busy_o, mb_done_o,
        output bot_tc_o, right_tc_o
    );

    modport master (
        output mb_start_i, mb_abort_i, left_avail_i, top_avail_i,
        output left_tc_i, top_tc_i, level_i, wr_req_i, block_done_i,
        input  blk_start_o, blk_idx_o, blk_nc_o, busy_o, mb_done_o,
        input  bot_tc_o, right_tc_o
    );
endinterface

// File: rtl/cavlc_mb_sequencer.sv
// Walks the 16 luma 4x4 blocks of a macroblock through the CAVLC core in
// 8x8-quadrant scan order, predicting nC and tallying TotalCoeff per block.
module cavlc_mb_sequencer #(
    parameter int unsigned LEVEL_W = 13,
    parameter int unsigned TC_W    = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cavlc_mb_sequencer_if.slave  bus
);
    localparam int unsigned NBLK  = 16;
    localparam int unsigned ROW_W = 4 * TC_W;
    localparam int unsigned TCV_W = NBLK * TC_W;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [3:0]         blk_idx_q, blk_idx_d;
    logic [TC_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [TCV_W-1:0]   tc_q, tc_d;
    logic [TC_W-1:0]    blk_nc_q, blk_nc_d, nc_c;
    logic               blk_start_q, blk_start_d;
    logic               busy_q, busy_d;
    logic               mb_done_q, mb_done_d;
    logic [ROW_W-1:0]   bot_tc_q, bot_tc_d;
    logic [ROW_W-1:0]   right_tc_q, right_tc_d;

    logic [1:0]         pos_x, pos_y;
    logic               a_ok, b_ok;
    logic [TC_W-1:0]    n_a, n_b;
    logic [5:0]         sum_ab;

    // Scan index from block coordinates: idx = {y1, x1, y0, x0}
    function automatic logic [3:0] pos_idx(input logic [1:0] x, input logic [1:0] y);
        return {y[1], x[1], y[0], x[0]};
    endfunction

    function automatic logic [TC_W-1:0] tc_at(input logic [TCV_W-1:0] v, input logic [3:0] idx);
        return v[int'(idx)*TC_W +: TC_W];
    endfunction

    // nC prediction for the block at blk_idx_q from finished blocks or neighbour MBs
    always_comb begin
        pos_x  = {blk_idx_q[2], blk_idx_q[0]};
        pos_y  = {blk_idx_q[3], blk_idx_q[1]};
        a_ok   = (pos_x != 2'd0) || bus.left_avail_i;
        b_ok   = (pos_y != 2'd0) || bus.top_avail_i;
        n_a    = (pos_x != 2'd0) ? tc_at(tc_q, pos_idx(pos_x - 2'd1, pos_y))
                                 : bus.left_tc_i[int'(pos_y)*TC_W +: TC_W];
        n_b    = (pos_y != 2'd0) ? tc_at(tc_q, pos_idx(pos_x, pos_y - 2'd1))
                                 : bus.top_tc_i[int'(pos_x)*TC_W +: TC_W];
        sum_ab = 6'(n_a) + 6'(n_b) + 6'd1;
        if (a_ok && b_ok) begin
            nc_c = TC_W'(sum_ab >> 1);
        end else if (a_ok) begin
            nc_c = n_a;
        end else if (b_ok) begin
            nc_c = n_b;
        end else begin
            nc_c = '0;
        end
    end

    // Non-zero level counter, saturating at 16 coefficients
    always_comb begin
        cnt_inc = cnt_q;
        if (bus.wr_req_i && (bus.level_i != LEVEL_W'(0)) && (cnt_q != TC_W'(NBLK))) begin
            cnt_inc = cnt_q + TC_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        blk_idx_d  = blk_idx_q;
        cnt_d      = cnt_q;
        tc_d       = tc_q;
        blk_nc_d   = blk_nc_q;
        bot_tc_d   = bot_tc_q;
        right_tc_d = right_tc_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.mb_start_i) begin
                    state_d   = S_ISSUE;
                    blk_idx_d = 4'd0;
                    cnt_d     = '0;
                    tc_d      = '0;
                end
            end
            S_ISSUE: begin
                blk_nc_d = nc_c;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                if (bus.block_done_i) begin
                    tc_d[int'(blk_idx_q)*TC_W +: TC_W] = cnt_inc;
                    cnt_d = '0;
                    if (blk_idx_q == 4'd15) begin
                        state_d = S_DONE;
                    end else begin
                        blk_idx_d = blk_idx_q + 4'd1;
                        state_d   = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Neighbour export is captured on entry to DONE so it is valid with MbDone
        if (state_d == S_DONE) begin
            for (int i = 0; i < 4; i++) begin
                bot_tc_d[i*TC_W +: TC_W]   = tc_at(tc_d, pos_idx(2'(i), 2'd3));
                right_tc_d[i*TC_W +: TC_W] = tc_at(tc_d, pos_idx(2'd3, 2'(i)));
            end
        end

        if (bus.mb_abort_i) begin
            state_d    = S_IDLE;
            bot_tc_d   = bot_tc_q;
            right_tc_d = right_tc_q;
        end

        blk_start_d = (state_d == S_ISSUE);
        mb_done_d   = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            blk_idx_q   <= 4'd0;
            cnt_q       <= '0;
            tc_q        <= '0;
            blk_nc_q    <= '0;
            blk_start_q <= 1'b0;
            busy_q      <= 1'b0;
            mb_done_q   <= 1'b0;
            bot_tc_q    <= '0;
            right_tc_q  <= '0;
        end else begin
            state_q     <= state_d;
            blk_idx_q   <= blk_idx_d;
            cnt_q       <= cnt_d;
            tc_q        <= tc_d;
            blk_nc_q    <= blk_nc_d;
            blk_start_q <= blk_start_d;
            busy_q      <= busy_d;
            mb_done_q   <= mb_done_d;
            bot_tc_q    <= bot_tc_d;
            right_tc_q  <= right_tc_d;
        end
    end

    assign bus.blk_start_o = blk_start_q;
    assign bus.blk_idx_o   = blk_idx_q;
    assign bus.blk_nc_o    = blk_nc_q;
    assign bus.busy_o      = busy_q;
    assign bus.mb_done_o   = mb_done_q;
    assign bus.bot_tc_o    = bot_tc_q;
    assign bus.right_tc_o  = right_tc_q;
endmodule

// File: tb/tb_cavlc_mb_sequencer.sv
// Scoreboard bench for cavlc_mb_sequencer: directed macroblocks with
// hand-computed nC per block and neighbour exports.
module tb_cavlc_mb_sequencer;
    localparam int unsigned LEVEL_W = 13;
    localparam int unsigned TC_W    = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    cavlc_mb_sequencer_if #(.LEVEL_W(LEVEL_W), .TC_W(TC_W)) bus ();

    cavlc_mb_sequencer #(.LEVEL_W(LEVEL_W), .TC_W(TC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct { int idx; int nc; } blk_exp_t;
    typedef struct { logic [19:0] bot; logic [19:0] right; } mb_exp_t;

    blk_exp_t blk_q[$];
    mb_exp_t  mb_q[$];
    int checks = 0;
    int errors = 0;

    // Hand-derived nC per scan index
    int nc_zero [16] = '{0,0,0,0, 0,0,0,0, 0,0,0,0, 0,0,0,0};
    int nc_mb2  [16] = '{1,5,4,0, 0,0,0,0, 2,0,2,2, 0,0,0,0};
    int nc_mb3  [16] = '{4,9,8,2, 2,3,0,0, 0,0,0,0, 0,0,0,0};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_blocks(input int n, input int tab[16]);
        blk_exp_t e;
        for (int i = 0; i < n; i++) begin
            e.idx = i;
            e.nc  = tab[i];
            blk_q.push_back(e);
        end
    endtask

    task automatic push_mb(input logic [19:0] bot, input logic [19:0] right);
        mb_exp_t e;
        e.bot   = bot;
        e.right = right;
        mb_q.push_back(e);
    endtask

    // Monitor: pops expectations whenever the DUT presents BlkStart or MbDone
    bit nc_pending = 1'b0;
    int nc_exp     = 0;
    always @(negedge clk) begin
        blk_exp_t be;
        mb_exp_t  me;
        if (!rst_n) begin
            nc_pending = 1'b0;
            blk_q.delete();
            mb_q.delete();
        end else begin
            if (nc_pending) begin
                check("blk_nc", 32'(bus.blk_nc_o), nc_exp);
                check("busy_in_wait", 32'(bus.busy_o), 1);
                nc_pending = 1'b0;
            end
            if (bus.blk_start_o) begin
                if (blk_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_blk_start: got idx %0d expected no start", bus.blk_idx_o);
                end else begin
                    be = blk_q.pop_front();
                    check("blk_idx", 32'(bus.blk_idx_o), be.idx);
                    nc_exp     = be.nc;
                    nc_pending = 1'b1;
                end
            end
            if (bus.mb_done_o) begin
                if (mb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_mb_done: got 1 expected 0");
                end else begin
                    me = mb_q.pop_front();
                    check("bot_tc", 32'(bus.bot_tc_o), 32'(me.bot));
                    check("right_tc", 32'(bus.right_tc_o), 32'(me.right));
                end
            end
        end
    end

    task automatic wait_blk_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.blk_start_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL blk_start_timeout: got no start expected start within 40 cycles");
        end
    endtask

    task automatic start_mb(input bit la, input bit ta, input logic [19:0] ltc, input logic [19:0] ttc);
        bus.left_avail_i = la;
        bus.top_avail_i  = ta;
        bus.left_tc_i    = ltc;
        bus.top_tc_i     = ttc;
        bus.mb_start_i   = 1'b1;
        @(posedge clk); #1;
        bus.mb_start_i   = 1'b0;
        check("start_latency", 32'(bus.blk_start_o), 1);
        check("busy_after_start", 32'(bus.busy_o), 1);
    endtask

    // Core emulator for one block: zero writes, then nz non-zero writes, then BlockDone
    task automatic serve_block(input int idx, input int nz, input int zeros, input bit coinc, input bit poke);
        bit ok;
        wait_blk_start(ok);
        if (!ok) return;
        @(posedge clk); #1;
        if (poke) begin
            bus.mb_start_i = 1'b1;
            @(posedge clk); #1;
            bus.mb_start_i = 1'b0;
        end
        for (int i = 0; i < zeros; i++) begin
            bus.wr_req_i = 1'b1;
            bus.level_i  = '0;
            @(posedge clk); #1;
        end
        for (int i = 0; i < nz; i++) begin
            bus.wr_req_i     = 1'b1;
            bus.level_i      = (i % 2 == 1) ? 13'h1FFF : LEVEL_W'(i + 1);
            bus.block_done_i = coinc && (i == nz - 1);
            @(posedge clk); #1;
        end
        bus.wr_req_i = 1'b0;
        bus.level_i  = '0;
        if (!(coinc && nz > 0)) begin
            bus.block_done_i = 1'b1;
            @(posedge clk); #1;
        end
        bus.block_done_i = 1'b0;
        if (idx < 15) check("next_start_latency", 32'(bus.blk_start_o), 1);
        else          check("mb_done_latency", 32'(bus.mb_done_o), 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_blk_start"}, 32'(bus.blk_start_o), 0);
        check({tag, "_blk_idx"},   32'(bus.blk_idx_o), 0);
        check({tag, "_blk_nc"},    32'(bus.blk_nc_o), 0);
        check({tag, "_busy"},      32'(bus.busy_o), 0);
        check({tag, "_mb_done"},   32'(bus.mb_done_o), 0);
        check({tag, "_bot_tc"},    32'(bus.bot_tc_o), 0);
        check({tag, "_right_tc"},  32'(bus.right_tc_o), 0);
    endtask

    task automatic finish_mb();
        @(posedge clk); #1;
        check("mb_done_one_cycle", 32'(bus.mb_done_o), 0);
        check("busy_after_done", 32'(bus.busy_o), 0);
        check("blk_q_drained", 32'(blk_q.size()), 0);
        check("mb_q_drained", 32'(mb_q.size()), 0);
    endtask

    initial begin
        bit ok;
        bus.mb_start_i   = 1'b0;
        bus.mb_abort_i   = 1'b0;
        bus.left_avail_i = 1'b0;
        bus.top_avail_i  = 1'b0;
        bus.left_tc_i    = '0;
        bus.top_tc_i     = '0;
        bus.level_i      = '0;
        bus.wr_req_i     = 1'b0;
        bus.block_done_i = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // MB1: no neighbours, empty blocks, stray MbStart during block 5
        push_blocks(16, nc_zero);
        push_mb(20'd0, 20'd0);
        start_mb(1'b0, 1'b0, 20'd0, 20'd0);
        for (int i = 0; i < 16; i++) serve_block(i, 0, (i == 3) ? 2 : 0, 1'b0, i == 5);
        finish_mb();

        // MB2: left neighbour only, tc[0]=5, tc[10]=3, tc[15]=2
        push_blocks(16, nc_mb2);
        push_mb(20'd65539, 20'd65536);
        start_mb(1'b1, 1'b0, {5'd4, 5'd3, 5'd2, 5'd1}, 20'd0);
        for (int i = 0; i < 16; i++)
            serve_block(i, (i == 0) ? 5 : (i == 10) ? 3 : (i == 15) ? 2 : 0, (i == 0) ? 1 : 0, 1'b0, 1'b0);
        finish_mb();

        // MB4: abort during block 7 WAIT
        push_blocks(8, nc_zero);
        start_mb(1'b0, 1'b0, 20'd0, 20'd0);
        for (int i = 0; i < 7; i++) serve_block(i, 0, 0, 1'b0, 1'b0);
        wait_blk_start(ok);
        @(posedge clk); #1;
        bus.wr_req_i = 1'b1;
        bus.level_i  = LEVEL_W'(7);
        @(posedge clk); #1;
        bus.wr_req_i   = 1'b0;
        bus.mb_abort_i = 1'b1;
        @(posedge clk); #1;
        bus.mb_abort_i = 1'b0;
        check("abort_busy", 32'(bus.busy_o), 0);
        check("abort_blk_start", 32'(bus.blk_start_o), 0);
        bus.block_done_i = 1'b1;
        bus.wr_req_i     = 1'b1;
        bus.level_i      = LEVEL_W'(3);
        repeat (3) @(posedge clk);
        #1;
        bus.block_done_i = 1'b0;
        bus.wr_req_i     = 1'b0;
        bus.level_i      = '0;
        check("idle_ignores_core_busy", 32'(bus.busy_o), 0);
        check("abort_bot_kept", 32'(bus.bot_tc_o), 65539);
        check("abort_right_kept", 32'(bus.right_tc_o), 65536);
        check("abort_blk_q_drained", 32'(blk_q.size()), 0);

        // MB5: restart after abort, then async reset in block 3 WAIT
        push_blocks(4, nc_zero);
        start_mb(1'b0, 1'b0, 20'd0, 20'd0);
        for (int i = 0; i < 3; i++) serve_block(i, 0, 0, 1'b0, 1'b0);
        wait_blk_start(ok);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midmb_reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // MB3: both neighbours, saturation in blk0, coincident write+done in blk1
        push_blocks(16, nc_mb3);
        push_mb(20'd0, 20'd0);
        start_mb(1'b1, 1'b1, {5'd0, 5'd0, 5'd0, 5'd4}, {5'd6, 5'd0, 5'd1, 5'd3});
        serve_block(0, 20, 3, 1'b0, 1'b0);
        serve_block(1, 3, 2, 1'b1, 1'b0);
        for (int i = 2; i < 16; i++) serve_block(i, 0, 0, 1'b0, 1'b0);
        finish_mb();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
